// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Imported by the round-robin picker and the arbiter top.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int ROM_AW = 6;
  localparam int ROM_DW = 32;

endpackage

// File: rtl/rom_rr_pick.sv
// Combinational two-port round-robin picker: the pointer only matters
// when both ports request at once.
module rom_rr_pick
  import rom_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = PORT_IF;
    if (i_req == 2'b11) begin
      o_grant_id = i_ptr;
    end else if (i_req[PORT_DM]) begin
      o_grant_id = PORT_DM;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-ported instruction ROM between instruction fetch and the
// data-memory load path: round-robin grant, timed ROM enable, registered data.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int AW          = ROM_AW,
  parameter int DW          = ROM_DW
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_req,
  input  logic [AW-1:0] dm_addr,
  output logic          if_ack,
  output logic          dm_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] rom_addr,
  output logic          rom_nce,
  output logic          rom_re,
  input  logic [DW-1:0] rom_data
);

  // Counter only ever holds WAIT_CYCLES-1 down to 0.
  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_winner;
  logic          r_ptr;
  logic [DW-1:0] r_rdata;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic          w_winner_nxt;
  logic          w_ptr_nxt;
  logic [DW-1:0] w_rdata_nxt;
  logic          w_grant_valid;
  logic          w_grant_id;

  rom_rr_pick u_pick (
    .i_req         ({dm_req, if_req}),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_winner <= PORT_IF;
      r_ptr    <= PORT_IF;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_winner <= w_winner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_winner_nxt = r_winner;
    w_ptr_nxt    = r_ptr;
    w_rdata_nxt  = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_addr_nxt   = (w_grant_id == PORT_DM) ? dm_addr : if_addr;
          w_winner_nxt = w_grant_id;
          w_ptr_nxt    = ~w_grant_id;
          w_cnt_nxt    = CNT_LOAD;
          w_state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_rdata_nxt = rom_data;
          w_state_nxt = RESP;
        end
      end
      // Requests are deliberately ignored here so an acked port is not re-granted.
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign rom_nce  = (r_state != ACCESS);
  assign rom_re   = (r_state == ACCESS);
  assign busy     = (r_state == ACCESS) || (r_state == RESP);
  assign if_ack   = (r_state == RESP) && (r_winner == PORT_IF);
  assign dm_ack   = (r_state == RESP) && (r_winner == PORT_DM);
  assign rom_addr = r_addr;
  assign rdata    = r_rdata;

endmodule
